// File: rtl/load_fire_scheduler_if.sv
// load_fire_scheduler_if
//   Data-memory load request channel (valid/ready).
//   master: scheduler side, drives the request and samples ready.
//   slave : memory side, samples the request and drives ready.
//   mem_req_valid   request pending
//   mem_req_ready   memory accepts this cycle
//   mem_req_address load address
//   mem_req_rob_tag ROB tag of the load
//   mem_req_ldq_idx load queue index of the load
interface load_fire_scheduler_if #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int LDQ_SIZE      = 16
);
  localparam int IW = $clog2(LDQ_SIZE);

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [XLEN-1:0]          mem_req_address;
  logic [ROB_TAG_WIDTH-1:0] mem_req_rob_tag;
  logic [IW-1:0]            mem_req_ldq_idx;

  modport master (
    output mem_req_valid, mem_req_address, mem_req_rob_tag, mem_req_ldq_idx,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_address, mem_req_rob_tag, mem_req_ldq_idx,
    output mem_req_ready
  );
endinterface

// File: rtl/load_fire_scheduler.sv
// load_fire_scheduler
//   Picks the oldest ready-to-issue load queue entry (age order from
//   ldq_head, wrapping) and presents it on the load port with a registered
//   valid/ready request. Outstanding loads are capped at MAX_INFLIGHT.
// Ports:
//   clk, reset (async, active low)
//   ldq_head, ldq_valid/address_valid/fired/completed/blocked : queue state
//   ldq_address, ldq_rob_tag : flattened per-entry payload
//   flush          : drop pending request, no selection this edge
//   load_completed : one outstanding load returned
//   mem_req        : request channel (master modport)
//   mark_fired/_idx: accept strobe back to the load queue
//   inflight_count : outstanding loads
// Optional: define LDQ_FIRE_PERF_EN to add perf_fire_count and
//   perf_stall_count (32-bit wrapping event counters).
module load_fire_scheduler #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int LDQ_SIZE      = 16,
  parameter int MAX_INFLIGHT  = 4,
  localparam int IW = $clog2(LDQ_SIZE),
  localparam int CW = $clog2(MAX_INFLIGHT+1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [IW-1:0]                     ldq_head,
  input  logic [LDQ_SIZE-1:0]               ldq_valid,
  input  logic [LDQ_SIZE-1:0]               ldq_address_valid,
  input  logic [LDQ_SIZE-1:0]               ldq_fired,
  input  logic [LDQ_SIZE-1:0]               ldq_completed,
  input  logic [LDQ_SIZE-1:0]               ldq_blocked,
  input  logic [LDQ_SIZE*XLEN-1:0]          ldq_address,
  input  logic [LDQ_SIZE*ROB_TAG_WIDTH-1:0] ldq_rob_tag,
  input  logic                              flush,
  input  logic                              load_completed,
  load_fire_scheduler_if.master             mem_req,
  output logic                              mark_fired,
  output logic [IW-1:0]                     mark_fired_idx,
  output logic [CW-1:0]                     inflight_count
`ifdef LDQ_FIRE_PERF_EN
  ,
  output logic [31:0]                       perf_fire_count,
  output logic [31:0]                       perf_stall_count
`endif
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d, sel, cand;
  logic [XLEN-1:0]          addr_q, addr_d;
  logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [LDQ_SIZE-1:0]      elig, elig_m;
  logic                     acc, found, room, sel_en, load;

  assign elig = ldq_valid & ldq_address_valid & ~ldq_fired & ~ldq_completed & ~ldq_blocked;
  assign acc  = (state_q == PENDING) & mem_req.mem_req_ready;

  // The queue only sees mark_fired at this edge, so its fired bit is still
  // clear; hide the accepted entry from the back-to-back selection.
  always_comb begin
    elig_m = elig;
    if (acc) elig_m[idx_q] = 1'b0;
  end

  // Oldest-first scan starting at the head; index arithmetic wraps naturally
  // because LDQ_SIZE is a power of two.
  always_comb begin
    found = 1'b0;
    sel   = ldq_head;
    cand  = '0;
    for (int k = 0; k < LDQ_SIZE; k++) begin
      cand = ldq_head + IW'(k);
      if (!found && elig_m[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Cap check counts a same-edge accept but not a same-edge completion.
  assign room   = acc ? (32'(cnt_q) + 32'd1 < 32'(MAX_INFLIGHT))
                      : (32'(cnt_q) < 32'(MAX_INFLIGHT));
  assign sel_en = found & ~flush & room;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && !load_completed)                      cnt_d = cnt_q + CW'(1);
    else if (!acc && load_completed && cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    load    = 1'b0;
    if (state_q == IDLE) begin
      load = sel_en;
    end else if (flush) begin
      state_d = IDLE;
    end else if (acc || !elig[idx_q]) begin
      // accepted, or held entry went stale: reselect or fall back to IDLE
      if (sel_en) load    = 1'b1;
      else        state_d = IDLE;
    end
    if (load) begin
      state_d = PENDING;
      idx_d   = sel;
      addr_d  = ldq_address[sel*XLEN +: XLEN];
      tag_d   = ldq_rob_tag[sel*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req.mem_req_valid   = (state_q == PENDING);
  assign mem_req.mem_req_address = addr_q;
  assign mem_req.mem_req_rob_tag = tag_q;
  assign mem_req.mem_req_ldq_idx = idx_q;
  assign mark_fired              = acc;
  assign mark_fired_idx          = idx_q;
  assign inflight_count          = cnt_q;

`ifdef LDQ_FIRE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fire_count  <= '0;
      perf_stall_count <= '0;
    end else begin
      if (acc) perf_fire_count <= perf_fire_count + 32'd1;
      if ((state_q == PENDING) && !mem_req.mem_req_ready)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_fire_scheduler.sv
// tb_load_fire_scheduler
//   Directed bench for load_fire_scheduler (LDQ_SIZE=16, MAX_INFLIGHT=4).
//   The bench plays the load queue: it sets fired bits after each accept
//   it expects, and drives completions/flush/ready by hand.
module tb_load_fire_scheduler;
  localparam int XLEN = 32;
  localparam int TW   = 32;
  localparam int N    = 16;

  logic              clk, reset;
  logic [3:0]        head;
  logic [N-1:0]      v, av, fi, co, bl;
  logic [N*XLEN-1:0] addr;
  logic [N*TW-1:0]   tag;
  logic              flush, lc;
  logic              mf;
  logic [3:0]        mf_idx;
  logic [2:0]        cnt;
`ifdef LDQ_FIRE_PERF_EN
  logic [31:0]       pfire, pstall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  load_fire_scheduler_if #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW), .LDQ_SIZE(N)) mif ();

  load_fire_scheduler #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW), .LDQ_SIZE(N), .MAX_INFLIGHT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .ldq_head          (head),
    .ldq_valid         (v),
    .ldq_address_valid (av),
    .ldq_fired         (fi),
    .ldq_completed     (co),
    .ldq_blocked       (bl),
    .ldq_address       (addr),
    .ldq_rob_tag       (tag),
    .flush             (flush),
    .load_completed    (lc),
    .mem_req           (mif.master),
    .mark_fired        (mf),
    .mark_fired_idx    (mf_idx),
    .inflight_count    (cnt)
`ifdef LDQ_FIRE_PERF_EN
    ,
    .perf_fire_count   (pfire),
    .perf_stall_count  (pstall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", nm, got, exp);
    end
  endtask

  // advance one edge, settle 2 time units after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_q();
    v = '0; av = '0; fi = '0; co = '0; bl = '0;
    addr = '0; tag = '0; head = '0;
  endtask

  task automatic set_ent(input int i, input logic [31:0] a, input logic [31:0] t);
    v[i]  = 1'b1;
    av[i] = 1'b1;
    addr[i*XLEN +: XLEN] = a;
    tag[i*TW +: TW]      = t;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; lc = 1'b0; mif.mem_req_ready = 1'b0;
    clr_q();
    #3;
    chk("rst_valid", 64'(mif.mem_req_valid), 64'd0);
    chk("rst_cnt",   64'(cnt), 64'd0);
    chk("rst_addr",  64'(mif.mem_req_address), 64'd0);
    chk("rst_mf",    64'(mf), 64'd0);
`ifdef LDQ_FIRE_PERF_EN
    chk("rst_pfire",  64'(pfire), 64'd0);
    chk("rst_pstall", 64'(pstall), 64'd0);
`endif
    #9 reset = 1'b1;

    // single entry 3
    set_ent(3, 32'h100, 32'd7);
    mif.mem_req_ready = 1'b1;
    tick();
    chk("t1_valid", 64'(mif.mem_req_valid), 64'd1);
    chk("t1_addr",  64'(mif.mem_req_address), 64'h100);
    chk("t1_tag",   64'(mif.mem_req_rob_tag), 64'd7);
    chk("t1_idx",   64'(mif.mem_req_ldq_idx), 64'd3);
    chk("t1_mf",    64'(mf), 64'd1);
    chk("t1_mfidx", 64'(mf_idx), 64'd3);
    fi[3] = 1'b1;
    tick();
    chk("t1_cnt",    64'(cnt), 64'd1);
    chk("t1_idle",   64'(mif.mem_req_valid), 64'd0);
    lc = 1'b1;
    tick();
    chk("t1_cnt0",   64'(cnt), 64'd0);
    lc = 1'b0;

    // wrap-around age order
    head = 4'd14;
    set_ent(15, 32'h150, 32'd15);
    set_ent(2,  32'h020, 32'd2);
    tick();
    chk("t2_idx15",  64'(mif.mem_req_ldq_idx), 64'd15);
    chk("t2_addr15", 64'(mif.mem_req_address), 64'h150);
    fi[15] = 1'b1;
    tick();
    chk("t2_idx2",   64'(mif.mem_req_ldq_idx), 64'd2);
    chk("t2_tag2",   64'(mif.mem_req_rob_tag), 64'd2);
    chk("t2_v2",     64'(mif.mem_req_valid), 64'd1);
    chk("t2_cnt1",   64'(cnt), 64'd1);
    fi[2] = 1'b1;
    tick();
    chk("t2_idle",   64'(mif.mem_req_valid), 64'd0);
    chk("t2_cnt2",   64'(cnt), 64'd2);
    lc = 1'b1;
    tick();
    tick();
    lc = 1'b0;
    chk("t2_cnt0",   64'(cnt), 64'd0);
    tick();
    chk("t2_sat0",   64'(cnt), 64'd0);

    // inflight cap
    clr_q();
    for (int k = 0; k < 6; k++) set_ent(k, 32'h1000 + 32'(k) * 32'h10, 32'h20 + 32'(k));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_valid", 64'(mif.mem_req_valid), 64'd1);
      chk("t3_idx",   64'(mif.mem_req_ldq_idx), 64'(k));
      chk("t3_cnt",   64'(cnt), 64'(k));
      fi[k] = 1'b1;
    end
    tick();
    chk("t3_capv",  64'(mif.mem_req_valid), 64'd0);
    chk("t3_cap4",  64'(cnt), 64'd4);
    tick();
    chk("t3_capv2", 64'(mif.mem_req_valid), 64'd0);
    lc = 1'b1;
    tick();
    chk("t3_cnt3",  64'(cnt), 64'd3);
    lc = 1'b0;
    mif.mem_req_ready = 1'b0;
    tick();
    chk("t3_5th_v",   64'(mif.mem_req_valid), 64'd1);
    chk("t3_5th_idx", 64'(mif.mem_req_ldq_idx), 64'd4);

    // held request stays stable, then drops when blocked
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_v",   64'(mif.mem_req_valid), 64'd1);
      chk("t4_hold_a",   64'(mif.mem_req_address), 64'h1040);
      chk("t4_hold_t",   64'(mif.mem_req_rob_tag), 64'h24);
      chk("t4_hold_mf",  64'(mf), 64'd0);
    end
    bl[4] = 1'b1;
    bl[5] = 1'b1;
    tick();
    chk("t4_drop_v",  64'(mif.mem_req_valid), 64'd0);
    chk("t4_drop_mf", 64'(mf), 64'd0);
    chk("t4_cnt3",    64'(cnt), 64'd3);

    // accept + completion same edge, then flush
    lc = 1'b1;
    tick();
    lc = 1'b0;
    chk("t5_cnt2", 64'(cnt), 64'd2);
    bl[5] = 1'b0;
    mif.mem_req_ready = 1'b1;
    tick();
    chk("t5_idx5", 64'(mif.mem_req_ldq_idx), 64'd5);
    chk("t5_mf",   64'(mf), 64'd1);
    lc = 1'b1;
    fi[5] = 1'b1;
    tick();
    chk("t5_same", 64'(cnt), 64'd2);
    chk("t5_idle", 64'(mif.mem_req_valid), 64'd0);
    lc = 1'b0;
    bl[4] = 1'b0;
    mif.mem_req_ready = 1'b0;
    tick();
    chk("t5_pend4", 64'(mif.mem_req_ldq_idx), 64'd4);
    flush = 1'b1;
    tick();
    chk("t5_flush_v", 64'(mif.mem_req_valid), 64'd0);
    chk("t5_flush_c", 64'(cnt), 64'd2);
    flush = 1'b0;
    tick();
    chk("t5_resel", 64'(mif.mem_req_valid), 64'd1);

    // asynchronous reset mid-request
    mif.mem_req_ready = 1'b1;
    #1;
    chk("t6_mf_pre", 64'(mf), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_valid", 64'(mif.mem_req_valid), 64'd0);
    chk("t6_addr",  64'(mif.mem_req_address), 64'd0);
    chk("t6_idx",   64'(mif.mem_req_ldq_idx), 64'd0);
    chk("t6_cnt",   64'(cnt), 64'd0);
    chk("t6_mf",    64'(mf), 64'd0);
    clr_q();
    mif.mem_req_ready = 1'b0;
    #1 reset = 1'b1;

    // empty queue stays idle
    tick();
    chk("t7_empty", 64'(mif.mem_req_valid), 64'd0);

`ifdef LDQ_FIRE_PERF_EN
    set_ent(1, 32'h300, 32'd9);
    tick();
    chk("t8_v", 64'(mif.mem_req_valid), 64'd1);
    tick(); tick(); tick();
    mif.mem_req_ready = 1'b1;
    tick();
    chk("t8_stall", 64'(pstall), 64'd3);
    chk("t8_fire",  64'(pfire), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
